// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Two-requester byte scheduler in front of the UART transmitter. Port 0 (CPU
// store path) and port 1 (debug/trace path) are arbitrated into a shared FIFO.
// A small FSM then hands one byte at a time to the transmitter using its
// send_req/busy handshake.
//
// Configuration macro:
//   UART_SCHED_RR_EN  defined   -> round-robin arbitration between the ports
//                     undefined -> fixed priority, port 0 always wins
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   REQ_TIMEOUT  cycles spent in S_REQ waiting for tx_busy before aborting
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0_valid/data/ready port 0 byte handshake
//   req1_valid/data/ready port 1 byte handshake
//   tx_send_req          request to the transmitter (high in S_REQ)
//   tx_byte              FIFO head byte (8'h00 while the FIFO is empty)
//   tx_data_clk          2'b10 while tx_send_req is high, else 2'b00
//   tx_busy              transmitter busy
//   fifo_count           occupied FIFO entries
//   fifo_full/fifo_empty FIFO status flags
//   tx_err               sticky handshake-timeout flag
//   err_clr              synchronous clear of tx_err (a new timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int DEPTH       = 16,
  parameter int REQ_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [7:0]             req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [7:0]             req1_data,
  output logic                   req1_ready,
  output logic                   tx_send_req,
  output logic [7:0]             tx_byte,
  output logic [1:0]             tx_data_clk,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   tx_err,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          grant0;
  logic          grant1;
  logic          push;
  logic [7:0]    push_data;
  logic          pop;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] to_cnt;
  logic          send_req;
  logic          set_err;

  // Flags come straight from the registered count, so a pop in the cycle the
  // FIFO is full cannot open the push path until the following cycle.
  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef UART_SCHED_RR_EN
  // rr_ptr names the port that wins the next contested cycle.
  logic rr_ptr;
  logic contested;

  assign contested = req0_valid & req1_valid;
  assign grant0    = req0_valid & (!req1_valid | !rr_ptr);
  assign grant1    = req1_valid & (!req0_valid |  rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (contested && !fifo_full) begin
      // The port just served drops to lowest priority.
      rr_ptr <= grant0;
    end
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & !req0_valid;
`endif

  assign req0_ready = !fifo_full & grant0;
  assign req1_ready = !fifo_full & grant1;

  // Grants are mutually exclusive, so at most one push happens per cycle.
  assign push      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign push_data = grant0 ? req0_data : req1_data;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally at DEPTH.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the data array has no reset; a reset only clears the pointers and
  // count, and the head is masked to 8'h00 while empty, so stale contents are
  // never observable and the array can map onto plain RAM or un-reset flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign tx_byte = fifo_empty ? 8'h00 : mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Transmit sequencer
  // ---------------------------------------------------------------------------
  // Reset lands in S_WAIT: the transmitter has no reset, so a frame that was
  // in flight must finish (busy low) before a new request is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_WAIT;
      to_cnt <= '0;
    end else begin
      state  <= next_state;
      // Counts cycles spent in S_REQ; cleared everywhere else.
      to_cnt <= (state == S_REQ) ? to_cnt + TW'(1) : '0;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    send_req   = 1'b0;
    pop        = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !tx_busy) next_state = S_REQ;
      end
      S_REQ: begin
        send_req = 1'b1;
        if (tx_busy) begin
          // Transmitter has latched the head byte; retire it.
          pop        = 1'b1;
          next_state = S_WAIT;
        end else if (to_cnt == TW'(REQ_TIMEOUT - 1)) begin
          // Abort without popping; the same byte is retried from S_IDLE.
          set_err    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!tx_busy) next_state = S_IDLE;
      end
      default: next_state = S_WAIT;
    endcase
  end

  assign tx_send_req = send_req;
  assign tx_data_clk = send_req ? 2'b10 : 2'b00;

  // ---------------------------------------------------------------------------
  // Sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_err <= 1'b0;
    end else if (set_err) begin
      tx_err <= 1'b1;
    end else if (err_clr) begin
      tx_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Self-checking bench for uart_tx_scheduler. A behavioural transmitter model
// raises busy one cycle after it sees send_req with data_clk == 2'b10 and holds
// it for a 100-cycle frame, recording each transmitted byte. A vector table
// covers arbitration/ready/count behaviour; hand-written sequences cover the
// multi-cycle cases (ordering, full FIFO, timeout, reset mid-frame,
// simultaneous push and pop).
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;
  localparam int FRAME = 100;

`ifdef UART_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_send_req;
  logic [7:0] tx_byte;
  logic [1:0] tx_data_clk;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_err;
  logic       err_clr;

  uart_tx_scheduler #(.DEPTH(DEPTH), .REQ_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_send_req(tx_send_req),
    .tx_byte    (tx_byte),
    .tx_data_clk(tx_data_clk),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .tx_err     (tx_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Advance to just after the next falling edge, away from the active edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Transmitter model
  // ---------------------------------------------------------------------------
  logic       model_en   = 1'b0;
  int         busy_left  = 0;
  int         violations = 0;
  logic [7:0] frames[$];
  logic [7:0] exp_q[$];

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_left > 0) begin
        if (tx_send_req) violations++;
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (model_en && tx_send_req && tx_data_clk == 2'b10) begin
        tx_busy   = 1'b1;
        busy_left = FRAME;
        frames.push_back(tx_byte);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    err_clr    = 1'b0;
    nxt();
    rst_n = 1'b1;
    frames.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    int n = 0;
    while (tx_busy && n < 300) begin
      nxt();
      n++;
    end
    apply_reset();
  endtask

  task automatic push(input bit port, input logic [7:0] d);
    int n = 0;
    if (port) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    #1;
    while (!(port ? req1_ready : req0_ready) && n < 3000) begin
      nxt();
      n++;
    end
    if (n >= 3000) bound_fail("push_ready");
    nxt();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    logic [7:0] got;
    while (frames.size() < exp_q.size() && n < budget) begin
      nxt();
      n++;
    end
    if (frames.size() < exp_q.size()) bound_fail({name, "_frames"});
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 8'hxx;
      if (i < frames.size()) got = frames[i];
      check($sformatf("%s_frame%0d", name, i), 32'(got), 32'(exp_q[i]));
    end
    n = 0;
    while (tx_busy && n < 200) begin
      nxt();
      n++;
    end
    repeat (4) nxt();
    check({name, "_nframes"}, frames.size(), exp_q.size());
    check({name, "_empty"}, 32'(fifo_empty), 32'd1);
    frames.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied for one cycle with the transmitter stalled
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    int         cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ia;
    int ib;
    logic a_acc;
    logic b_acc;
    logic flag;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b1, 8'h12, 1'b1, 8'h22, !RR,  RR,   4};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4};

    // ---- reset state --------------------------------------------------------
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    err_clr    = 1'b0;
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_send_req", 32'(tx_send_req), 32'd0);
    check("rst_data_clk", 32'(tx_data_clk), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();

    // ---- table-driven arbitration / count -----------------------------------
    model_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = vecs[i].v0;
      req0_data  = vecs[i].d0;
      req1_valid = vecs[i].v1;
      req1_data  = vecs[i].d1;
      #1;
      check($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      check($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      nxt();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].cnt == 0));
    end
    check("vec_head", 32'(tx_byte), 32'h10);
    model_en = 1'b1;
    exp_q = '{8'h10, 8'h20, 8'h11, (RR ? 8'h22 : 8'h12)};
    drain("vec", 4 * 110);

    // ---- three bytes on port 0 ----------------------------------------------
    do_reset();
    model_en = 1'b1;
    push(1'b0, 8'h41);
    push(1'b0, 8'h42);
    push(1'b0, 8'h43);
    check("abc_count", 32'(fifo_count), 32'd2);
    exp_q = '{8'h41, 8'h42, 8'h43};
    drain("abc", 3 * 110);
    check("abc_err", 32'(tx_err), 32'd0);

    // ---- both ports streaming -----------------------------------------------
    do_reset();
    model_en = 1'b1;
    ia = 0;
    ib = 0;
    n  = 0;
    while ((ia < 4 || ib < 4) && n < 100) begin
      req0_valid = (ia < 4);
      req0_data  = 8'(8'hA0 + ia);
      req1_valid = (ib < 4);
      req1_data  = 8'(8'hB0 + ib);
      #1;
      a_acc = req0_valid && req0_ready;
      b_acc = req1_valid && req1_ready;
      nxt();
      if (a_acc) ia++;
      if (b_acc) ib++;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("ab_accepted", 32'(ia + ib), 32'd8);
    for (int i = 0; i < 4; i++) begin
      if (RR) begin
        exp_q.push_back(8'(8'hA0 + i));
        exp_q.push_back(8'(8'hB0 + i));
      end else begin
        exp_q.push_back(8'(8'hA0 + i));
      end
    end
    if (!RR) for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hB0 + i));
    drain("ab", 8 * 110);

    // ---- simultaneous push and pop at count 1 -------------------------------
    do_reset();
    model_en = 1'b1;
    push(1'b0, 8'h31);
    n = 0;
    while (!(tx_send_req && tx_busy) && n < 20) begin
      nxt();
      n++;
    end
    if (n >= 20) bound_fail("pp_pop_cycle");
    req0_valid = 1'b1;
    req0_data  = 8'h32;
    #1;
    check("pp_ready", 32'(req0_ready), 32'd1);
    nxt();
    req0_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd1);
    check("pp_head", 32'(tx_byte), 32'h32);
    exp_q = '{8'h31, 8'h32};
    drain("pp", 2 * 110);

    // ---- fill to DEPTH with the transmitter stalled -------------------------
    do_reset();
    model_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(1'b0, 8'(8'h80 + i));
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_empty", 32'(fifo_empty), 32'd0);
    req0_valid = 1'b1;
    req0_data  = 8'h90;
    #1;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (req0_ready) flag = 1'b1;
      nxt();
    end
    check("full_ready_held", 32'(flag), 32'd0);
    check("full_count_held", 32'(fifo_count), 32'd16);
    model_en = 1'b1;
    n = 0;
    while (!req0_ready && n < 300) begin
      nxt();
      n++;
    end
    if (n >= 300) bound_fail("full_release");
    nxt();
    req0_valid = 1'b0;
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(8'(8'h80 + i));
    drain("full", 17 * 110);

    // ---- handshake timeout and tx_err ---------------------------------------
    do_reset();
    model_en = 1'b0;
    push(1'b0, 8'h5A);
    n = 0;
    while (!tx_send_req && n < 10) begin
      nxt();
      n++;
    end
    check("to_err_before", 32'(tx_err), 32'd0);
    n = 0;
    while (tx_send_req && n < 40) begin
      n++;
      nxt();
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_err_set", 32'(tx_err), 32'd1);
    check("to_byte_kept", 32'(fifo_count), 32'd1);
    check("to_head", 32'(tx_byte), 32'h5A);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    check("to_err_clr", 32'(tx_err), 32'd0);
    check("to_retry", 32'(tx_send_req), 32'd1);
    err_clr = 1'b1;
    n = 0;
    while (tx_send_req && n < 40) begin
      n++;
      nxt();
    end
    check("to_set_wins", 32'(tx_err), 32'd1);
    nxt();
    check("to_clr_after", 32'(tx_err), 32'd0);
    err_clr = 1'b0;

    // ---- reset in the middle of a frame -------------------------------------
    model_en = 1'b1;
    n = 0;
    while (!tx_busy && n < 40) begin
      nxt();
      n++;
    end
    if (n >= 40) bound_fail("mid_start");
    exp_q.push_back(8'h5A);
    push(1'b0, 8'h61);
    push(1'b0, 8'h62);
    repeat (20) nxt();
    check("mid_count_pre", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check("mid_rst_send_req", 32'(tx_send_req), 32'd0);
    check("mid_rst_data_clk", 32'(tx_data_clk), 32'd0);
    check("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
    nxt();
    rst_n = 1'b1;
    push(1'b0, 8'h77);
    flag = 1'b0;
    n = 0;
    while (tx_busy && n < 200) begin
      if (tx_send_req) flag = 1'b1;
      nxt();
      n++;
    end
    check("mid_no_req_busy", 32'(flag), 32'd0);
    exp_q.push_back(8'h77);
    drain("mid", 2 * 110);

    check("model_overlap", 32'(violations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
